victim_swap_ctrl: RTL and testbench

- Miss-handling controller between the data cache and the victim cache.
- On a dcache miss it probes the victim cache combinationally and fills from it on a hit; on a victim miss it fetches the line from memory.
- In both cases it writes the line the dcache is displacing into the victim cache, then returns the fill line to the dcache.
- Also keeps saturating hit/miss counters for performance monitoring.

---
 rtl/victim_swap_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_victim_swap_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/victim_swap_ctrl.sv
// victim_swap_ctrl: miss-handling controller between the dcache and the victim cache.
// On a dcache miss the victim cache is probed. A hit fills from the victim cache and a
// miss fetches the line from memory. In both cases the displaced dcache line is then
// written into the victim cache, and the fill line is returned with a one-cycle ack.
// Ports:
//   clk, rst (async, active-low), flush_i (sync clear, highest priority)
//   miss_req_i/miss_addr_i/evict_*_i        : miss request from the dcache
//   miss_ack_o/fill_data_o/fill_from_victim_o : fill response to the dcache
//   victim_wr_en_o/victim_addr_o/victim_data_o, victim_hit_i/victim_data_i : victim cache
//   mem_req_o/mem_addr_o, mem_ack_i/mem_data_i : memory line read
//   stat_hits_o/stat_misses_o               : saturating victim hit/miss counters
module victim_swap_ctrl #(
  parameter int unsigned DCACHE_LINE_WIDTH = 128,
  parameter int unsigned VICTIM_ADDR_BITS  = 28,
  parameter int unsigned STAT_WIDTH        = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          miss_req_i,
  input  logic [VICTIM_ADDR_BITS-1:0]   miss_addr_i,
  input  logic                          evict_valid_i,
  input  logic [VICTIM_ADDR_BITS-1:0]   evict_addr_i,
  input  logic [DCACHE_LINE_WIDTH-1:0]  evict_data_i,
  output logic                          miss_ack_o,
  output logic [DCACHE_LINE_WIDTH-1:0]  fill_data_o,
  output logic                          fill_from_victim_o,
  output logic                          victim_wr_en_o,
  output logic [VICTIM_ADDR_BITS-1:0]   victim_addr_o,
  output logic [DCACHE_LINE_WIDTH-1:0]  victim_data_o,
  input  logic                          victim_hit_i,
  input  logic [DCACHE_LINE_WIDTH-1:0]  victim_data_i,
  output logic                          mem_req_o,
  output logic [VICTIM_ADDR_BITS-1:0]   mem_addr_o,
  input  logic                          mem_ack_i,
  input  logic [DCACHE_LINE_WIDTH-1:0]  mem_data_i,
  output logic [STAT_WIDTH-1:0]         stat_hits_o,
  output logic [STAT_WIDTH-1:0]         stat_misses_o
);

  localparam int unsigned LW = DCACHE_LINE_WIDTH;
  localparam int unsigned AW = VICTIM_ADDR_BITS;
  localparam int unsigned SW = STAT_WIDTH;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PROBE    = 3'd1,
    MEM_WAIT = 3'd2,
    EVICT    = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e          state_q, state_d;

  // Captured request and fill bookkeeping
  logic [AW-1:0]   miss_addr_q,   miss_addr_d;
  logic            evict_valid_q, evict_valid_d;
  logic [AW-1:0]   evict_addr_q,  evict_addr_d;
  logic [LW-1:0]   evict_data_q,  evict_data_d;
  logic [LW-1:0]   fill_q,        fill_d;
  logic            from_victim_q, from_victim_d;
  logic [SW-1:0]   stat_hits_q,   stat_hits_d;
  logic [SW-1:0]   stat_misses_q, stat_misses_d;

  // Registered outputs
  logic            miss_ack_q,         miss_ack_d;
  logic [LW-1:0]   fill_data_q,        fill_data_d;
  logic            fill_from_victim_q, fill_from_victim_d;
  logic            victim_wr_en_q,     victim_wr_en_d;
  logic [AW-1:0]   victim_addr_q,      victim_addr_d;
  logic [LW-1:0]   victim_data_q,      victim_data_d;
  logic            mem_req_q,          mem_req_d;
  logic [AW-1:0]   mem_addr_q,         mem_addr_d;

  // Increment that sticks at all-ones
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (&v) ? v : v + SW'(1);
  endfunction

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= IDLE;
      miss_addr_q        <= '0;
      evict_valid_q      <= 1'b0;
      evict_addr_q       <= '0;
      evict_data_q       <= '0;
      fill_q             <= '0;
      from_victim_q      <= 1'b0;
      stat_hits_q        <= '0;
      stat_misses_q      <= '0;
      miss_ack_q         <= 1'b0;
      fill_data_q        <= '0;
      fill_from_victim_q <= 1'b0;
      victim_wr_en_q     <= 1'b0;
      victim_addr_q      <= '0;
      victim_data_q      <= '0;
      mem_req_q          <= 1'b0;
      mem_addr_q         <= '0;
    end else begin
      state_q            <= state_d;
      miss_addr_q        <= miss_addr_d;
      evict_valid_q      <= evict_valid_d;
      evict_addr_q       <= evict_addr_d;
      evict_data_q       <= evict_data_d;
      fill_q             <= fill_d;
      from_victim_q      <= from_victim_d;
      stat_hits_q        <= stat_hits_d;
      stat_misses_q      <= stat_misses_d;
      miss_ack_q         <= miss_ack_d;
      fill_data_q        <= fill_data_d;
      fill_from_victim_q <= fill_from_victim_d;
      victim_wr_en_q     <= victim_wr_en_d;
      victim_addr_q      <= victim_addr_d;
      victim_data_q      <= victim_data_d;
      mem_req_q          <= mem_req_d;
      mem_addr_q         <= mem_addr_d;
    end
  end

  // Next state, captures, and Moore outputs decoded from the next state so they register
  // in step with it
  always_comb begin
    state_d            = state_q;
    miss_addr_d        = miss_addr_q;
    evict_valid_d      = evict_valid_q;
    evict_addr_d       = evict_addr_q;
    evict_data_d       = evict_data_q;
    fill_d             = fill_q;
    from_victim_d      = from_victim_q;
    stat_hits_d        = stat_hits_q;
    stat_misses_d      = stat_misses_q;
    miss_ack_d         = 1'b0;
    fill_data_d        = '0;
    fill_from_victim_d = 1'b0;
    victim_wr_en_d     = 1'b0;
    victim_addr_d      = '0;
    victim_data_d      = '0;
    mem_req_d          = 1'b0;
    mem_addr_d         = '0;

    if (flush_i) begin
      state_d       = IDLE;
      miss_addr_d   = '0;
      evict_valid_d = 1'b0;
      evict_addr_d  = '0;
      evict_data_d  = '0;
      fill_d        = '0;
      from_victim_d = 1'b0;
      stat_hits_d   = '0;
      stat_misses_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_req_i) begin
            miss_addr_d   = miss_addr_i;
            evict_valid_d = evict_valid_i;
            evict_addr_d  = evict_addr_i;
            evict_data_d  = evict_data_i;
            state_d       = PROBE;
          end
        end
        PROBE: begin
          if (victim_hit_i) begin
            fill_d        = victim_data_i;
            from_victim_d = 1'b1;
            stat_hits_d   = sat_inc(stat_hits_q);
            state_d       = EVICT;
          end else begin
            stat_misses_d = sat_inc(stat_misses_q);
            state_d       = MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ack_i) begin
            fill_d        = mem_data_i;
            from_victim_d = 1'b0;
            state_d       = EVICT;
          end
        end
        EVICT:   state_d = DONE;
        // Always return to IDLE so the still-high miss_req_i is not re-accepted here
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase

      case (state_d)
        PROBE: begin
          victim_addr_d = miss_addr_d;
        end
        MEM_WAIT: begin
          mem_req_d  = 1'b1;
          mem_addr_d = miss_addr_d;
        end
        EVICT: begin
          // Write only after the probe so a hit is read before the FIFO can overwrite it
          if (evict_valid_d) begin
            victim_wr_en_d = 1'b1;
            victim_addr_d  = evict_addr_d;
            victim_data_d  = evict_data_d;
          end
        end
        DONE: begin
          miss_ack_d         = 1'b1;
          fill_data_d        = fill_d;
          fill_from_victim_d = from_victim_d;
        end
        default: ;
      endcase
    end
  end

  assign miss_ack_o         = miss_ack_q;
  assign fill_data_o        = fill_data_q;
  assign fill_from_victim_o = fill_from_victim_q;
  assign victim_wr_en_o     = victim_wr_en_q;
  assign victim_addr_o      = victim_addr_q;
  assign victim_data_o      = victim_data_q;
  assign mem_req_o          = mem_req_q;
  assign mem_addr_o         = mem_addr_q;
  assign stat_hits_o        = stat_hits_q;
  assign stat_misses_o      = stat_misses_q;

endmodule

// File: tb/tb_victim_swap_ctrl.sv
// Bench for victim_swap_ctrl: a small victim cache model and a memory responder, a
// vector table of complete miss transactions, and hand sequences for flush,
// back-to-back requests, counter saturation and asynchronous reset.
module tb_victim_swap_ctrl;

  localparam int unsigned LW = 128;
  localparam int unsigned AW = 28;
  localparam int unsigned SW = 32;
  localparam int          BUDGET = 60;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          miss_req_i;
  logic [AW-1:0] miss_addr_i;
  logic          evict_valid_i;
  logic [AW-1:0] evict_addr_i;
  logic [LW-1:0] evict_data_i;
  logic          miss_ack_o;
  logic [LW-1:0] fill_data_o;
  logic          fill_from_victim_o;
  logic          victim_wr_en_o;
  logic [AW-1:0] victim_addr_o;
  logic [LW-1:0] victim_data_o;
  logic          victim_hit_i;
  logic [LW-1:0] victim_data_i;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ack_i;
  logic [LW-1:0] mem_data_i;
  logic [SW-1:0] stat_hits_o;
  logic [SW-1:0] stat_misses_o;

  victim_swap_ctrl #(
    .DCACHE_LINE_WIDTH(LW),
    .VICTIM_ADDR_BITS (AW),
    .STAT_WIDTH       (SW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .miss_req_i        (miss_req_i),
    .miss_addr_i       (miss_addr_i),
    .evict_valid_i     (evict_valid_i),
    .evict_addr_i      (evict_addr_i),
    .evict_data_i      (evict_data_i),
    .miss_ack_o        (miss_ack_o),
    .fill_data_o       (fill_data_o),
    .fill_from_victim_o(fill_from_victim_o),
    .victim_wr_en_o    (victim_wr_en_o),
    .victim_addr_o     (victim_addr_o),
    .victim_data_o     (victim_data_o),
    .victim_hit_i      (victim_hit_i),
    .victim_data_i     (victim_data_i),
    .mem_req_o         (mem_req_o),
    .mem_addr_o        (mem_addr_o),
    .mem_ack_i         (mem_ack_i),
    .mem_data_i        (mem_data_i),
    .stat_hits_o       (stat_hits_o),
    .stat_misses_o     (stat_misses_o)
  );

  always #5 clk = ~clk;

  // Four-entry victim cache model, looked up combinationally on the probe address
  logic [AW-1:0] vc_addr [4];
  logic [LW-1:0] vc_dat  [4];
  logic [3:0]    vc_valid;
  int            vc_ptr;

  always_comb begin
    victim_hit_i  = 1'b0;
    victim_data_i = '0;
    if (!victim_wr_en_o) begin
      for (int i = 0; i < 4; i++) begin
        if (vc_valid[i] && vc_addr[i] == victim_addr_o) begin
          victim_hit_i  = 1'b1;
          victim_data_i = vc_dat[i];
        end
      end
    end
  end

  int ack_cnt = 0;
  always @(negedge clk) if (miss_ack_o) ack_cnt++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic outs_any();
    return miss_ack_o | fill_from_victim_o | victim_wr_en_o | mem_req_o |
           (|fill_data_o) | (|victim_addr_o) | (|victim_data_o) | (|mem_addr_o) |
           (|stat_hits_o) | (|stat_misses_o);
  endfunction

  typedef struct {
    logic [AW-1:0] miss_addr;
    logic          ev_valid;
    logic [AW-1:0] ev_addr;
    logic [LW-1:0] ev_data;
    logic          preload;
    logic [LW-1:0] vc_data;
    logic [LW-1:0] mem_data;
    int            mem_delay;   // memory acks in this many-th cycle of mem_req
    logic [LW-1:0] exp_fill;
    logic          exp_fv;
    int            exp_ack_cyc; // cycles after the accepting edge
    int            exp_wr_cyc;  // -1: no victim write expected
    int            exp_memreq;  // cycles mem_req_o is high
  } vec_t;

  vec_t vecs [5];

  // One full miss transaction; miss_req_i is dropped after the edge that ends the ack cycle
  task automatic run_txn(input vec_t v, input string tag);
    int ack_cyc, wr_cyc, wr_n, memreq_n, memaddr_bad;
    logic probe_ok, fv;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] wr_data, fill;
    vc_valid = '0;
    vc_ptr   = 0;
    if (v.preload) begin
      vc_addr[0]  = v.miss_addr;
      vc_dat[0]   = v.vc_data;
      vc_valid[0] = 1'b1;
      vc_ptr      = 1;
    end
    @(negedge clk);
    miss_req_i    = 1'b1;
    miss_addr_i   = v.miss_addr;
    evict_valid_i = v.ev_valid;
    evict_addr_i  = v.ev_addr;
    evict_data_i  = v.ev_data;
    @(posedge clk);
    ack_cyc = -1; wr_cyc = -1; wr_n = 0; memreq_n = 0; memaddr_bad = 0;
    probe_ok = 1'b0; fv = 1'b0; fill = '0; wr_addr = '0; wr_data = '0;
    for (int c = 1; c <= BUDGET && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) probe_ok = (victim_addr_o == v.miss_addr) && !victim_wr_en_o;
      if (mem_req_o) begin
        memreq_n++;
        if (mem_addr_o != v.miss_addr) memaddr_bad++;
      end
      mem_ack_i  = mem_req_o && (memreq_n == v.mem_delay);
      mem_data_i = mem_ack_i ? v.mem_data : '0;
      if (victim_wr_en_o) begin
        wr_n++;
        wr_cyc  = c;
        wr_addr = victim_addr_o;
        wr_data = victim_data_o;
        vc_addr[vc_ptr % 4]  = victim_addr_o;
        vc_dat[vc_ptr % 4]   = victim_data_o;
        vc_valid[vc_ptr % 4] = 1'b1;
        vc_ptr++;
      end
      if (miss_ack_o) begin
        ack_cyc = c;
        fill    = fill_data_o;
        fv      = fill_from_victim_o;
      end
    end
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    chki({tag, "_ack_cycle"}, ack_cyc, v.exp_ack_cyc);
    chk ({tag, "_fill"}, fill, v.exp_fill);
    chk ({tag, "_from_victim"}, LW'(fv), LW'(v.exp_fv));
    chki({tag, "_probe_addr"}, int'(probe_ok), 1);
    chki({tag, "_victim_writes"}, wr_n, (v.exp_wr_cyc < 0) ? 0 : 1);
    chki({tag, "_memreq_cycles"}, memreq_n, v.exp_memreq);
    chki({tag, "_memaddr_bad"}, memaddr_bad, 0);
    if (v.exp_wr_cyc >= 0) begin
      chki({tag, "_wr_cycle"}, wr_cyc, v.exp_wr_cyc);
      chk ({tag, "_wr_addr"}, LW'(wr_addr), LW'(v.ev_addr));
      chk ({tag, "_wr_data"}, wr_data, v.ev_data);
    end
    @(posedge clk);
    #1 miss_req_i = 1'b0;
  endtask

  initial begin
    int   ack_base;
    vec_t b;
    vecs[0] = '{28'h0000ABC, 1'b1, 28'h0000123, {4{32'h22222222}}, 1'b1, {4{32'h11111111}},
                '0, 0, {4{32'h11111111}}, 1'b1, 3, 2, 0};
    vecs[1] = '{28'h0000456, 1'b1, 28'h0000789, {4{32'h33333333}}, 1'b0, '0,
                {4{32'h44444444}}, 5, {4{32'h44444444}}, 1'b0, 8, 7, 5};
    vecs[2] = '{28'h00000F0, 1'b0, 28'h0000FFF, {4{32'h77777777}}, 1'b1, {4{32'h55555555}},
                '0, 0, {4{32'h55555555}}, 1'b1, 3, -1, 0};
    vecs[3] = '{28'h0001000, 1'b0, 28'h0002000, {4{32'h88888888}}, 1'b0, '0,
                {4{32'h99999999}}, 1, {4{32'h99999999}}, 1'b0, 4, -1, 1};
    vecs[4] = '{28'hFFFFFFF, 1'b1, 28'h0000001, {4{32'hAAAAAAAA}}, 1'b0, '0,
                {4{32'h66666666}}, 3, {4{32'h66666666}}, 1'b0, 6, 5, 3};

    rst = 1'b0; flush_i = 1'b0; miss_req_i = 1'b0; miss_addr_i = '0;
    evict_valid_i = 1'b0; evict_addr_i = '0; evict_data_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    vc_valid = '0; vc_ptr = 0;
    repeat (3) @(negedge clk);
    chki("reset_outputs_zero", int'(outs_any()), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chki("idle_outputs_zero", int'(outs_any()), 0);

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));
    @(negedge clk);
    chk("stat_hits_after_table", LW'(stat_hits_o), LW'(2));
    chk("stat_misses_after_table", LW'(stat_misses_o), LW'(3));

    // Back-to-back hits, request re-raised in the cycle after each ack
    ack_base = ack_cnt;
    for (int r = 0; r < 3; r++) begin
      b = vecs[0];
      b.miss_addr = 28'h0000100 + AW'(r);
      b.ev_addr   = 28'h0000200 + AW'(r);
      run_txn(b, $sformatf("b2b%0d", r));
    end
    repeat (8) @(negedge clk);
    chki("b2b_total_acks", ack_cnt - ack_base, 3);

    // Flush while waiting on memory
    vc_valid = '0;
    @(negedge clk);
    miss_req_i = 1'b1; miss_addr_i = 28'h0000DEF; evict_valid_i = 1'b1;
    evict_addr_i = 28'h0000EEE; evict_data_i = {4{32'hBBBBBBBB}};
    for (int c = 0; c < 10 && !mem_req_o; c++) @(negedge clk);
    chki("flush_memreq_seen", int'(mem_req_o), 1);
    flush_i = 1'b1; miss_req_i = 1'b0;
    @(posedge clk);
    #1 flush_i = 1'b0;
    chki("flush_state_idle", int'(3'(dut.state_q)), 0);
    chki("flush_memreq_low", int'(mem_req_o), 0);
    ack_base = ack_cnt;
    @(negedge clk);
    mem_ack_i = 1'b1; mem_data_i = {4{32'hCCCCCCCC}};
    @(negedge clk);
    mem_ack_i = 1'b0; mem_data_i = '0;
    repeat (8) @(negedge clk);
    chki("flush_no_ack", ack_cnt - ack_base, 0);
    chk("flush_stat_hits", LW'(stat_hits_o), '0);
    chk("flush_stat_misses", LW'(stat_misses_o), '0);

    // Hit counter held at all-ones must not wrap
    @(negedge clk);
    force dut.stat_hits_q = {SW{1'b1}};
    @(negedge clk);
    release dut.stat_hits_q;
    @(negedge clk);
    chk("sat_preload", LW'(stat_hits_o), LW'({SW{1'b1}}));
    run_txn(vecs[0], "sat");
    @(negedge clk);
    chk("sat_stat_hits", LW'(stat_hits_o), LW'({SW{1'b1}}));

    // Asynchronous reset in the middle of EVICT
    vc_valid = '0;
    vc_addr[0] = vecs[0].miss_addr; vc_dat[0] = vecs[0].vc_data; vc_valid[0] = 1'b1;
    @(negedge clk);
    miss_req_i = 1'b1; miss_addr_i = vecs[0].miss_addr; evict_valid_i = 1'b1;
    evict_addr_i = vecs[0].ev_addr; evict_data_i = vecs[0].ev_data;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chki("arst_in_evict", int'(victim_wr_en_o), 1);
    miss_req_i = 1'b0;
    #2 rst = 1'b0;
    #1 chki("arst_outputs_zero", int'(outs_any()), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chki("arst_idle_after", int'(outs_any()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
